// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e    : loader FSM states
//   IMEM_WORDS : default instruction-memory depth in 32-bit words
//   XLEN       : instruction width in bits
package rv_pkg;

  localparam int unsigned IMEM_WORDS = 64;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   clear      : synchronous clear of the byte counter and partial word
//   byte_valid : byte_in is consumed this cycle
//   byte_in    : incoming byte
//   word       : {byte_in, b2, b1, b0}; meaningful when word_done is high
//   word_done  : the current byte completes a word
module word_assembler
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_in,
  output logic [XLEN-1:0] word,
  output logic            word_done
);

  logic [1:0]  byte_cnt;
  // Bytes enter at the top, so after three bytes this holds {b2, b1, b0}.
  logic [23:0] low_bytes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {byte_in, low_bytes[23:8]};
    end
  end

  // The fourth byte is used straight from the input so the word is ready
  // on the same edge that accepts it.
  assign word      = {byte_in, low_bytes};
  assign word_done = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into the instruction memory and keeps the core in
// reset until a complete, checksum-clean image is in place.
// Image format: len[7:0], len[15:8], len little-endian 32-bit words, XOR
// checksum of all preceding bytes.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   start      : one-cycle pulse that begins (or restarts) a load
//   rx_data    : stream byte
//   rx_valid   : rx_data is valid
//   rx_ready   : loader accepts a byte this cycle
//   imem_we    : instruction-memory write strobe (one cycle per word)
//   imem_waddr : word address being written
//   imem_wdata : instruction word being written
//   core_reset : active-high reset to the core
//   busy       : a load is in progress
//   done       : image loaded and verified
//   error      : load failed; held until the next start
// ADDR_W must satisfy 2**ADDR_W >= MEM_WORDS.
module imem_loader
  import rv_pkg::*;
#(
  parameter int unsigned MEM_WORDS = IMEM_WORDS,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so the index can reach len == MEM_WORDS.
  localparam int unsigned IdxW        = ADDR_W + 1;
  localparam logic [15:0] MemWordsLen = 16'(MEM_WORDS);

  state_e            state;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [IdxW-1:0]   word_idx;
  logic [IdxW-1:0]   word_idx_nxt;
  logic [15:0]       new_len;
  logic              loading;
  logic              accept;
  logic              restart;
  logic              data_byte;
  logic              word_done;
  logic [XLEN-1:0]   word;

  always_comb begin
    loading = 1'b0;
    unique case (state)
      StLenLo, StLenHi, StData, StCsum: loading = 1'b1;
      default:                          loading = 1'b0;
    endcase
  end

  // The byte-accepting states are exactly the busy states.
  assign rx_ready     = loading;
  assign busy         = loading;
  assign accept       = rx_valid && rx_ready;
  assign restart      = start && !loading;
  assign data_byte    = accept && (state == StData);
  assign new_len      = {rx_data, len[7:0]};
  assign word_idx_nxt = word_idx + IdxW'(1);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (restart),
    .byte_valid (data_byte),
    .byte_in    (rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      len        <= 16'd0;
      csum       <= 8'd0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        state      <= StLenLo;
        len        <= 16'd0;
        csum       <= 8'd0;
        word_idx   <= '0;
        core_reset <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end else begin
        unique case (state)
          StIdle: ;
          StLenLo: begin
            if (accept) begin
              len[7:0] <= rx_data;
              csum     <= csum ^ rx_data;
              state    <= StLenHi;
            end
          end
          StLenHi: begin
            if (accept) begin
              len[15:8] <= rx_data;
              csum      <= csum ^ rx_data;
              if (new_len == 16'd0) begin
                state <= StCsum;
              end else if (new_len > MemWordsLen) begin
                state <= StErr;
              end else begin
                state <= StData;
              end
            end
          end
          StData: begin
            if (accept) begin
              csum <= csum ^ rx_data;
              if (word_done) begin
                imem_we    <= 1'b1;
                imem_waddr <= word_idx[ADDR_W-1:0];
                imem_wdata <= word;
                word_idx   <= word_idx_nxt;
                if (16'(word_idx_nxt) == len) begin
                  state <= StCsum;
                end
              end
            end
          end
          StCsum: begin
            if (accept) begin
              state <= (rx_data == csum) ? StDone : StErr;
            end
          end
          // Status flags follow the state by one cycle.
          StDone: begin
            done       <= 1'b1;
            core_reset <= 1'b0;
          end
          StErr: begin
            error      <= 1'b1;
            core_reset <= 1'b1;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the core's instruction memory: streams a program image into I_Mem before the core fetches from it.
- Accepts a byte stream over a valid/ready handshake and parses it into:
  - a 16-bit word-count header,
  - 32-bit little-endian instruction words,
  - a trailing XOR checksum byte.
- Drives the instruction-memory write port, one word per write.
- Holds the core in reset until a complete, checksum-clean image has been loaded.

Parameters:
- MEM_WORDS, 64: instruction-memory depth in 32-bit words.
- ADDR_W, 6: width of the word address; must satisfy 2**ADDR_W >= MEM_WORDS.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a load.
- rx_data, input, 8: incoming stream byte.
- rx_valid, input, 1: rx_data is valid.
- rx_ready, output, 1: loader accepts a byte this cycle.
- imem_we, output, 1: instruction-memory write enable, one-cycle pulse.
- imem_waddr, output, ADDR_W: word index being written.
- imem_wdata, output, 32: instruction word being written.
- core_reset, output, 1: active-high reset to the PC, register file and instruction memory.
- busy, output, 1: a load is in progress.
- done, output, 1: image loaded and verified.
- error, output, 1: load failed; sticky.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State = IDLE.
  - core_reset=1; rx_ready=0, imem_we=0, busy=0, done=0, error=0.
  - imem_waddr=0, imem_wdata=0; all internal counters and the checksum register cleared.
- Handshake: a byte is accepted on a rising edge where rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM.
  - rx_data is ignored when no byte is accepted.
- States:
  - IDLE: on start go to LEN_LO; clear csum, byte_cnt and word_idx; core_reset=1, busy=1.
  - LEN_LO: accepted byte becomes len[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte becomes len[15:8].
    - len==0 goes to CSUM.
    - len>MEM_WORDS goes to ERR.
    - Otherwise go to DATA.
  - DATA: bytes are assembled little-endian (byte 0 is wdata[7:0]); byte_cnt counts 0..3.
    - The 4th byte registers imem_wdata={b3,b2,b1,b0} and imem_waddr=word_idx.
    - imem_we pulses for exactly one cycle, the cycle after the 4th byte is accepted.
    - word_idx then increments.
    - When word_idx reaches len, go to CSUM.
    - rx_ready stays 1 during the write cycle; back-to-back bytes are legal.
  - CSUM: accepted byte is compared with the running XOR of every header and data byte.
    - Match goes to DONE.
    - Mismatch goes to ERR.
  - DONE: done=1, busy=0, core_reset=0 starting the cycle after entry.
  - ERR: error=1, busy=0, core_reset stays 1.
- Checksum: an 8-bit XOR accumulated on every accepted byte from LEN_LO through the last DATA byte.
- start handling:
  - In DONE or ERR, start restarts the load: clears done and error, reasserts core_reset the next cycle, goes to LEN_LO.
  - In any busy state, start is ignored.
- Stalls: rx_valid=0 for any number of cycles holds all state, with no timeout.
- Reset mid-load: the partial image is abandoned. Memory already written is not erased; core_reset stays 1 until a full successful load.
- Address wrap: cannot occur. len is bounded by MEM_WORDS, so imem_waddr never exceeds MEM_WORDS-1.
- Outputs imem_we, done, error and core_reset are registered.

Decomposition:
- Shared package (rv_pkg), holding:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - the IMEM_WORDS=64 constant;
  - the instruction width constant XLEN=32.
- One sub-module, word_assembler: byte_cnt, shift/assemble register and word-complete strobe. Keeps the FSM free of datapath.

Test Plan:
- Reset with reset_n=0, then release → core_reset=1, rx_ready=0, done=0, error=0, imem_we never asserted.
- Normal load: start, then bytes 01 00 93 00 50 00 C2 → one imem_we pulse with waddr=0, wdata=0x00500093; done=1; core_reset falls the cycle after DONE.
- Bad checksum: same stream with final byte C3 → imem_we fires once, error=1, core_reset remains 1; a following start clears error and accepts a new stream.
- Length checks:
  - Header 41 00 (65 words, exceeds MEM_WORDS) → ERR immediately after LEN_HI, no writes.
  - Header 00 00 followed by checksum 00 → DONE with no writes.
- Full depth with stalls: 64-word image with random rx_valid gaps → 64 writes to waddr 0..63 in order, correct data, done=1.
- Async reset mid-load: reset_n=0 in DATA after word 2 → outputs return to reset values immediately; start ignored while busy, confirmed on a separate run.
